eth_header_builder: RTL and testbench

//  Transmit-side Ethernet framer. Prepends a 14-byte header (dst MAC, src MAC, EtherType) to a byte-packed payload stream.

---
 rtl/eth_header_builder_pkg.sv | 34 +++
 rtl/eth_header_builder_if.sv | 18 +
 rtl/eth_header_builder_realign_buf.sv | 73 +++++++
 rtl/eth_header_builder.sv | 133 +++++++++++++
 tb/tb_eth_header_builder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_header_builder_pkg.sv
// Shared Ethernet framing definitions: header layout, EtherType constants,
// and the helper that flattens a header into its 14 wire-order bytes.
package eth_header_builder_pkg;

  localparam int ETH_HDR_BYTES = 14;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr_t;

  // Element [0] is the first byte on the wire.
  typedef logic [ETH_HDR_BYTES-1:0][7:0] eth_hdr_bytes_t;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } eth_state_e;

  function automatic eth_hdr_bytes_t eth_hdr_bytes(input eth_hdr_t hdr);
    eth_hdr_bytes_t           result;
    logic [ETH_HDR_BYTES*8-1:0] flat;
    flat = hdr;
    for (int i = 0; i < ETH_HDR_BYTES; i++) begin
      result[i] = flat[(ETH_HDR_BYTES-1-i)*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/eth_header_builder_if.sv
// Byte-packed beat stream (tdata/idx/valid/last with ready back-pressure),
// shared by the payload input and the framed output of the header builder.
interface eth_header_builder_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = $clog2(BYTES + 1);

  logic [DATA_WIDTH-1:0] tdata;
  logic [IDXW-1:0]       idx;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output tdata, idx, valid, last, input ready);
  modport slave  (input tdata, idx, valid, last, output ready);

endinterface

// File: rtl/eth_header_builder_realign_buf.sv
// 2*BYTES byte FIFO-like realignment buffer: pops up to BYTES bytes from the
// head and appends a partial beat at the tail in the same cycle.
module byte_realign_buf
  import eth_header_builder_pkg::*;
#(
  parameter int BYTES = 8,
  parameter int IDXW  = $clog2(BYTES + 1),
  parameter int CW    = $clog2(2 * BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  eth_hdr_bytes_t        load_bytes_i,
  input  logic [IDXW-1:0]       pop_i,
  input  logic                  push_i,
  input  logic [BYTES-1:0][7:0] push_data_i,
  input  logic [IDXW-1:0]       push_cnt_i,
  output logic [BYTES-1:0][7:0] head_o,
  output logic [CW-1:0]         cnt_o
);
  localparam int DEPTH = 2 * BYTES;

  logic [DEPTH-1:0][7:0] buf_q, buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  int                    base;

  // Head removal happens before the tail append, so the append offset is the
  // occupancy left after the pop.
  always_comb begin
    logic [7:0] shifted;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    shifted = 8'h00;
    base    = int'(cnt_q) - int'(pop_i);
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      buf_d = '0;
      for (int i = 0; i < ETH_HDR_BYTES; i++) begin
        buf_d[i] = load_bytes_i[i];
      end
      cnt_d = CW'(ETH_HDR_BYTES);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        shifted = 8'h00;
        for (int k = 0; k <= BYTES && i + k < DEPTH; k++) begin
          if (int'(pop_i) == k) shifted = buf_q[i+k];
        end
        buf_d[i] = shifted;
        for (int j = 0; j < BYTES; j++) begin
          if (push_i && j < int'(push_cnt_i) && i == base + j) buf_d[i] = push_data_i[j];
        end
      end
      cnt_d = CW'(base + (push_i ? int'(push_cnt_i) : 0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o = buf_q[BYTES-1:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/eth_header_builder.sv
// Transmit Ethernet framer: prepends dst MAC, src MAC and EtherType to a
// byte-packed payload stream and re-emits it on the same beat format.
module eth_header_builder
  import eth_header_builder_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          dst_mac,
  input  logic [47:0]          src_mac,
  input  logic [15:0]          eth_type,
  eth_header_builder_if.slave  payload_s,
  eth_header_builder_if.master frame_m,
  output logic                 eth_builder_busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = $clog2(BYTES + 1);
  localparam int CW    = $clog2(2 * BYTES + 1);

  if (DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_width
    $error("eth_header_builder: DATA_WIDTH must be 64 or 128");
  end

  eth_state_e            state_q;
  logic                  last_seen_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  last_q;
  logic [IDXW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  logic [CW-1:0]         cnt;
  logic [BYTES-1:0][7:0] head;
  logic [BYTES-1:0][7:0] emit_data;
  logic [IDXW-1:0]       emit_cnt;
  logic [IDXW-1:0]       pop_cnt;
  logic                  ready;
  logic                  accept;
  logic                  load;
  logic                  emit;
  logic                  emit_last;
  logic                  frame_done;
  eth_hdr_t              hdr;

  assign hdr = {dst_mac, src_mac, eth_type};

  // Ready only looks at registered state, so it never depends on data_valid_in.
  assign ready      = (state_q == ST_PAYLOAD) && !last_seen_q && (int'(cnt) <= BYTES);
  assign accept     = ready && payload_s.valid;
  assign load       = (state_q == ST_IDLE) && payload_s.valid;
  assign emit       = (state_q == ST_PAYLOAD) && (!valid_q || frame_m.ready) &&
                      ((int'(cnt) >= BYTES) || (last_seen_q && cnt != '0));
  assign emit_cnt   = (int'(cnt) >= BYTES) ? IDXW'(BYTES) : IDXW'(cnt);
  assign emit_last  = last_seen_q && (int'(cnt) <= BYTES);
  assign pop_cnt    = emit ? emit_cnt : '0;
  assign frame_done = valid_q && last_q && frame_m.ready;

  always_comb begin
    emit_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      emit_data[i] = (i < int'(emit_cnt)) ? head[i] : 8'h00;
    end
  end

  byte_realign_buf #(
    .BYTES (BYTES),
    .IDXW  (IDXW),
    .CW    (CW)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (frame_done),
    .load_i       (load),
    .load_bytes_i (eth_hdr_bytes(hdr)),
    .pop_i        (pop_cnt),
    .push_i       (accept),
    .push_data_i  (payload_s.tdata),
    .push_cnt_i   (payload_s.idx),
    .head_o       (head),
    .cnt_o        (cnt)
  );

  // Frame FSM plus the output register stage, which holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      tdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (payload_s.valid) begin
            state_q     <= ST_PAYLOAD;
            busy_q      <= 1'b1;
            last_seen_q <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          if (accept && payload_s.last) last_seen_q <= 1'b1;
          if (emit) begin
            valid_q <= 1'b1;
            tdata_q <= emit_data;
            idx_q   <= emit_cnt;
            last_q  <= emit_last;
          end else if (frame_m.ready) begin
            valid_q <= 1'b0;
          end
          if (frame_done) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            last_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign payload_s.ready  = ready;
  assign frame_m.tdata    = tdata_q;
  assign frame_m.idx      = idx_q;
  assign frame_m.valid    = valid_q;
  assign frame_m.last     = last_q;
  assign eth_builder_busy = busy_q;

endmodule

// File: tb/tb_eth_header_builder.sv
// Scoreboard bench for eth_header_builder: random frames are expanded into
// expected output beats by a byte-level model; a monitor pops and compares.
module tb_eth_header_builder;
   import eth_header_builder_pkg::*;

   localparam int BYTES = 8;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  idx;
      logic        last;
   } beat_t;

   typedef struct {
      logic [127:0] data;
      logic [4:0]   idx;
      logic         last;
   } beat128_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] dstMac, srcMac, dstMac128, srcMac128;
   logic [15:0] ethType, ethType128;
   logic        busy, busy128;

   int    checks = 0;
   int    failures = 0;
   int    beatsSeen = 0;
   int    idleRun = 0;
   int    lastGap = -1;
   bit    stallMode = 1'b0;
   bit    abortReq = 1'b0;
   bit    prevStalled = 1'b0;
   beat_t held;
   beat_t expQ[$];
   beat128_t got128[$];

   eth_header_builder_if #(.DATA_WIDTH(64))  payloadIf ();
   eth_header_builder_if #(.DATA_WIDTH(64))  frameIf ();
   eth_header_builder_if #(.DATA_WIDTH(128)) payload128If ();
   eth_header_builder_if #(.DATA_WIDTH(128)) frame128If ();

   eth_header_builder #(.DATA_WIDTH(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .dst_mac          (dstMac),
      .src_mac          (srcMac),
      .eth_type         (ethType),
      .payload_s        (payloadIf),
      .frame_m          (frameIf),
      .eth_builder_busy (busy)
   );

   eth_header_builder #(.DATA_WIDTH(128)) dut128 (
      .clk              (clk),
      .rst              (rst),
      .dst_mac          (dstMac128),
      .src_mac          (srcMac128),
      .eth_type         (ethType128),
      .payload_s        (payload128If),
      .frame_m          (frame128If),
      .eth_builder_busy (busy128)
   );

   always #5 clk = ~clk;

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Wire byte k of the Ethernet header, straight from the field layout.
   function automatic logic [7:0] hdrByte(input logic [47:0] d, input logic [47:0] s,
                                          input logic [15:0] t, input int k);
      if (k < 6)       return d[8*(5-k) +: 8];
      else if (k < 12) return s[8*(11-k) +: 8];
      else             return t[8*(13-k) +: 8];
   endfunction

   // Downstream ready: random back-pressure when stalling is enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         frameIf.ready = stallMode ? 1'($urandom % 2) : 1'b1;
      end
   end

   task automatic checkOutput();
      beat_t e;
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL unexpected_beat got data=%h idx=%0d last=%0b", frameIf.tdata, frameIf.idx, frameIf.last);
      end else begin
         e = expQ.pop_front();
         beatsSeen++;
         if (frameIf.tdata !== e.data || frameIf.idx !== e.idx || frameIf.last !== e.last) begin
            failures++;
            $display("[TB] FAIL out_beat got data=%h idx=%0d last=%0b need data=%h idx=%0d last=%0b",
                     frameIf.tdata, frameIf.idx, frameIf.last, e.data, e.idx, e.last);
         end
      end
   endtask

   // Monitor: scoreboard pops, stall stability and busy-idle gap tracking.
   always @(negedge clk) begin
      if (rst) begin
         prevStalled = 1'b0;
      end else begin
         if (busy) begin
            if (idleRun > 0) lastGap = idleRun;
            idleRun = 0;
         end else begin
            idleRun++;
         end
         if (prevStalled) begin
            checks++;
            if (!frameIf.valid || frameIf.tdata !== held.data || frameIf.idx !== held.idx || frameIf.last !== held.last) begin
               failures++;
               $display("[TB] FAIL stall_hold got valid=%0b data=%h idx=%0d need valid=1 data=%h idx=%0d",
                        frameIf.valid, frameIf.tdata, frameIf.idx, held.data, held.idx);
            end
         end
         if (frameIf.valid && frameIf.ready) checkOutput();
         prevStalled = frameIf.valid && !frameIf.ready;
         held.data = frameIf.tdata;
         held.idx  = frameIf.idx;
         held.last = frameIf.last;
      end
   end

   always @(negedge clk) begin
      beat128_t b;
      if (!rst && frame128If.valid && frame128If.ready) begin
         b.data = frame128If.tdata;
         b.idx  = frame128If.idx;
         b.last = frame128If.last;
         got128.push_back(b);
      end
   end

   // Builds the expected beats of one frame, then drives its payload beats.
   task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                input int nBytes, input bit fixedPayload);
      logic [7:0] payload[$];
      logic [7:0] frameBytes[$];
      beat_t      e;
      int         pos, n, cyc;
      bit         lst, done, sawIdle, scrambled, accepted;
      for (int i = 0; i < nBytes; i++) payload.push_back(fixedPayload ? 8'(i + 1) : 8'($urandom));
      for (int k = 0; k < 14; k++) frameBytes.push_back(hdrByte(d, s, t, k));
      foreach (payload[i]) frameBytes.push_back(payload[i]);
      for (int b = 0; b < frameBytes.size(); b += BYTES) begin
         e.data = '0;
         e.idx  = 4'(minInt(BYTES, frameBytes.size() - b));
         for (int j = 0; j < int'(e.idx); j++) e.data[8*j +: 8] = frameBytes[b+j];
         e.last = (b + BYTES >= frameBytes.size());
         expQ.push_back(e);
      end
      dstMac = d;
      srcMac = s;
      ethType = t;
      pos = 0;
      done = 1'b0;
      sawIdle = 1'b0;
      scrambled = 1'b0;
      while (!done && !abortReq) begin
         if (nBytes - pos == 0)  n = 0;
         else if (fixedPayload)  n = minInt(BYTES, nBytes - pos);
         else                    n = $urandom_range(minInt(BYTES, nBytes - pos), 1);
         lst = (pos + n == nBytes);
         if (lst && n > 0 && !fixedPayload && ($urandom % 4 == 0)) lst = 1'b0;
         payloadIf.tdata = {$urandom, $urandom};
         for (int j = 0; j < n; j++) payloadIf.tdata[8*j +: 8] = payload[pos+j];
         payloadIf.idx   = 4'(n);
         payloadIf.last  = lst;
         payloadIf.valid = 1'b1;
         accepted = 1'b0;
         for (cyc = 0; cyc < 1000 && !accepted && !abortReq; cyc++) begin
            @(negedge clk);
            if (!scrambled) begin
               if (!busy) sawIdle = 1'b1;
               else if (sawIdle) begin
                  dstMac = {16'($urandom), $urandom};
                  srcMac = {16'($urandom), $urandom};
                  ethType = 16'($urandom);
                  scrambled = 1'b1;
               end
            end
            if (!rst && payloadIf.valid && payloadIf.ready) begin
               @(posedge clk);
               #1;
               accepted = 1'b1;
            end
         end
         if (!accepted && !abortReq) begin
            checks++;
            failures++;
            $display("[TB] FAIL input_accept_timeout got no accept need accept within 1000 cycles");
            done = 1'b1;
         end
         pos += n;
         if (lst) done = 1'b1;
      end
      payloadIf.valid = 1'b0;
      payloadIf.last  = 1'b0;
      payloadIf.idx   = '0;
   endtask

   task automatic waitDrain(input string tag);
      for (int cyc = 0; cyc < 3000 && expQ.size() != 0; cyc++) @(negedge clk);
      if (expQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_drain_timeout got %0d beats pending need 0", tag, expQ.size());
         expQ.delete();
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_busy_clear got busy=%0b need 0", tag, busy);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checks++;
      if (frameIf.valid !== 1'b0 || frameIf.last !== 1'b0 || frameIf.idx !== '0 || frameIf.tdata !== '0 ||
          payloadIf.ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s got valid=%0b last=%0b idx=%0d tdata=%h ready=%0b busy=%0b need all 0",
                  tag, frameIf.valid, frameIf.last, frameIf.idx, frameIf.tdata, payloadIf.ready, busy);
      end
   endtask

   initial begin
      logic [47:0] d6, s6;
      logic [15:0] t6;
      logic [7:0]  bytes6[$];
      logic [7:0]  pay6[$];
      logic [47:0] gotDst, gotSrc;
      logic [15:0] gotType;
      beat128_t    e6;
      int          startBeats, cyc;
      bit          ok;

      rst = 1'b1;
      payloadIf.valid = 1'b0;
      payloadIf.last  = 1'b0;
      payloadIf.idx   = '0;
      payloadIf.tdata = '0;
      frameIf.ready   = 1'b1;
      payload128If.valid = 1'b0;
      payload128If.last  = 1'b0;
      payload128If.idx   = '0;
      payload128If.tdata = '0;
      frame128If.ready   = 1'b1;
      dstMac = '0; srcMac = '0; ethType = '0;
      dstMac128 = '0; srcMac128 = '0; ethType128 = '0;

      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset_outputs");
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkResetOutputs("idle_after_reset");

      $display("[TB] test 1: fixed single-beat frame and first-beat latency");
      fork
         applyStimulus(48'h001122334455, 48'h66778899AABB, ETHERTYPE_IPV4, 8, 1'b1);
         begin
            @(posedge clk);
            #1;
            checks++;
            if (frameIf.valid !== 1'b0 || payloadIf.ready !== 1'b0) begin
               failures++;
               $display("[TB] FAIL latency_cycle1 got valid=%0b ready=%0b need 0 0", frameIf.valid, payloadIf.ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (frameIf.valid !== 1'b1) begin
               failures++;
               $display("[TB] FAIL latency_cycle2 got valid=%0b need 1", frameIf.valid);
            end
         end
      join
      waitDrain("fixed");

      $display("[TB] test 2: header-only frame");
      @(posedge clk);
      #1;
      applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, ETHERTYPE_ARP, 0, 1'b0);
      waitDrain("hdr_only");

      $display("[TB] test 3: random frames with downstream stalls");
      stallMode = 1'b1;
      for (int f = 0; f < 3; f++) begin
         applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom),
                       $urandom_range(100, 1), 1'b0);
      end
      waitDrain("stall");
      stallMode = 1'b0;

      $display("[TB] test 4: back-to-back frames");
      @(posedge clk);
      #1;
      applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom), 20, 1'b0);
      applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom), 11, 1'b0);
      waitDrain("b2b");
      checks++;
      if (lastGap != 1) begin
         failures++;
         $display("[TB] FAIL b2b_idle_gap got %0d idle cycles need 1", lastGap);
      end

      $display("[TB] test 5: reset in the middle of a frame");
      startBeats = beatsSeen;
      fork
         applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom), 40, 1'b0);
         begin
            for (cyc = 0; cyc < 500 && beatsSeen < startBeats + 2; cyc++) @(negedge clk);
            if (beatsSeen < startBeats + 2) begin
               checks++;
               failures++;
               $display("[TB] FAIL midframe_timeout got %0d beats need 2", beatsSeen - startBeats);
            end
            @(posedge clk);
            #2;
            rst = 1'b1;
            abortReq = 1'b1;
            #1;
            checkResetOutputs("midframe_reset");
            expQ.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
         end
      join
      abortReq = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom),
                    $urandom_range(40, 1), 1'b0);
      waitDrain("after_reset");

      $display("[TB] test 6: 128-bit instance, 30-byte payload");
      d6 = {16'($urandom), $urandom};
      s6 = {16'($urandom), $urandom};
      t6 = ETHERTYPE_IPV4;
      for (int i = 0; i < 30; i++) pay6.push_back(8'($urandom));
      for (int k = 0; k < 14; k++) bytes6.push_back(hdrByte(d6, s6, t6, k));
      foreach (pay6[i]) bytes6.push_back(pay6[i]);
      got128.delete();
      @(posedge clk);
      #1;
      dstMac128 = d6;
      srcMac128 = s6;
      ethType128 = t6;
      for (int b = 0; b < 2; b++) begin
         payload128If.tdata = {$urandom, $urandom, $urandom, $urandom};
         for (int j = 0; j < ((b == 0) ? 16 : 14); j++) payload128If.tdata[8*j +: 8] = pay6[16*b + j];
         payload128If.idx   = (b == 0) ? 5'd16 : 5'd14;
         payload128If.last  = (b == 1);
         payload128If.valid = 1'b1;
         ok = 1'b0;
         for (cyc = 0; cyc < 200 && !ok; cyc++) begin
            @(negedge clk);
            if (payload128If.valid && payload128If.ready) begin
               @(posedge clk);
               #1;
               ok = 1'b1;
            end
         end
         if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL w128_accept_timeout got no accept need accept for beat %0d", b);
         end
      end
      payload128If.valid = 1'b0;
      payload128If.last  = 1'b0;
      for (cyc = 0; cyc < 200 && got128.size() < 3; cyc++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (got128.size() != 3) begin
         failures++;
         $display("[TB] FAIL w128_beat_count got %0d need 3", got128.size());
      end else begin
         for (int b = 0; b < 3; b++) begin
            e6.data = '0;
            e6.idx  = (b < 2) ? 5'd16 : 5'd12;
            for (int j = 0; j < int'(e6.idx); j++) e6.data[8*j +: 8] = bytes6[16*b + j];
            e6.last = (b == 2);
            checks++;
            if (got128[b].data !== e6.data || got128[b].idx !== e6.idx || got128[b].last !== e6.last) begin
               failures++;
               $display("[TB] FAIL w128_beat%0d got data=%h idx=%0d last=%0b need data=%h idx=%0d last=%0b",
                        b, got128[b].data, got128[b].idx, got128[b].last, e6.data, e6.idx, e6.last);
            end
         end
         for (int k = 0; k < 6; k++) begin
            gotDst[8*(5-k) +: 8] = got128[0].data[8*k +: 8];
            gotSrc[8*(5-k) +: 8] = got128[0].data[8*(k+6) +: 8];
         end
         gotType = {got128[0].data[8*12 +: 8], got128[0].data[8*13 +: 8]};
         checks++;
         if (gotDst !== d6 || gotSrc !== s6 || gotType !== t6) begin
            failures++;
            $display("[TB] FAIL w128_parse got dst=%h src=%h type=%h need dst=%h src=%h type=%h",
                     gotDst, gotSrc, gotType, d6, s6, t6);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
